sirv_plic_claim_icb_master: RTL

//  Hardware claim/complete agent: ICB initiator at the other end of the PLIC ICB slave port.
//  - On the PLIC hart-0 irq, reads the claim register and hands the claimed ID to a local consumer.
//  - When the consumer signals completion, writes that ID back to the complete register.
//  - Lets an accelerator or DMA service PLIC interrupts without the core.

---
 rtl/sirv_plic_claim_icb_master_pkg.sv | 17 +
 rtl/sirv_plic_claim_icb_master.sv | 131 +++++++++++++
 2 files changed

// File: rtl/sirv_plic_claim_icb_master_pkg.sv
// Shared FSM state encoding and default PLIC addresses for the hardware claim/complete agent.
package sirv_plic_claim_icb_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLM_CMD  = 3'd1,
        ST_CLM_RSP  = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_WAIT_CMP = 3'd4,
        ST_CMP_CMD  = 3'd5,
        ST_CMP_RSP  = 3'd6
    } claim_state_e;

    localparam logic [31:0] DEF_PLIC_BASE = 32'h0C00_0000;
    localparam logic [31:0] DEF_CLAIM_OFS = 32'h0020_0004;

endpackage

// File: rtl/sirv_plic_claim_icb_master.sv
// ICB initiator that claims PLIC hart-0 interrupts, hands the ID to a consumer and writes it back on completion.
// Optional feature: define SIRV_PLIC_CLAIM_SPUR_CNT_EN to add the saturating spurious-claim counter spur_cnt_o.
module sirv_plic_claim_icb_master
    import sirv_plic_claim_icb_master_pkg::*;
#(
    parameter logic [31:0] PLIC_BASE = DEF_PLIC_BASE,
    parameter logic [31:0] CLAIM_OFS = DEF_CLAIM_OFS,
    parameter int          ID_W      = 6,
    parameter int          REARM_DLY = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            enable_i,
    input  logic            irq_i,
    output logic            o_icb_cmd_valid,
    input  logic            o_icb_cmd_ready,
    output logic [31:0]     o_icb_cmd_addr,
    output logic            o_icb_cmd_read,
    output logic [31:0]     o_icb_cmd_wdata,
    input  logic            o_icb_rsp_valid,
    output logic            o_icb_rsp_ready,
    input  logic [31:0]     o_icb_rsp_rdata,
    output logic            claim_valid_o,
    input  logic            claim_ready_i,
    output logic [ID_W-1:0] claim_id_o,
    input  logic            cmplt_valid_i,
    output logic            cmplt_ready_o,
`ifdef SIRV_PLIC_CLAIM_SPUR_CNT_EN
    output logic [15:0]     spur_cnt_o,
`endif
    output logic            busy_o
);

    localparam int          CNT_W      = (REARM_DLY < 1) ? 1 : $clog2(REARM_DLY + 1);
    localparam logic [31:0] CLAIM_ADDR = PLIC_BASE + CLAIM_OFS;

    claim_state_e    state;
    logic [ID_W-1:0] id;
    logic [CNT_W-1:0] rearm_cnt;
    logic [ID_W-1:0] rsp_id;
    logic            rdata_hi_unused;

    assign rsp_id          = o_icb_rsp_rdata[ID_W-1:0];
    assign rdata_hi_unused = ^o_icb_rsp_rdata[31:ID_W];

`ifdef SIRV_PLIC_CLAIM_SPUR_CNT_EN
    logic [15:0] spur_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_cnt <= 16'd0;
        end else if (state == ST_CLM_RSP && o_icb_rsp_valid && rsp_id == '0 && spur_cnt != 16'hFFFF) begin
            spur_cnt <= spur_cnt + 16'd1;
        end
    end

    assign spur_cnt_o = spur_cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            id        <= '0;
            rearm_cnt <= '0;
        end else begin
            case (state)
                // Rearm delay hides the stale irq still flowing through the PLIC flops.
                ST_IDLE: begin
                    if (rearm_cnt != '0) begin
                        rearm_cnt <= rearm_cnt - 1'b1;
                    end
                    if (enable_i && irq_i && rearm_cnt == '0) begin
                        state <= ST_CLM_CMD;
                    end
                end
                ST_CLM_CMD: begin
                    if (o_icb_cmd_ready) begin
                        state <= ST_CLM_RSP;
                    end
                end
                ST_CLM_RSP: begin
                    if (o_icb_rsp_valid) begin
                        id <= rsp_id;
                        if (rsp_id == '0) begin
                            state     <= ST_IDLE;
                            rearm_cnt <= CNT_W'(REARM_DLY);
                        end else begin
                            state <= ST_PRESENT;
                        end
                    end
                end
                ST_PRESENT: begin
                    if (claim_ready_i) begin
                        state <= ST_WAIT_CMP;
                    end
                end
                ST_WAIT_CMP: begin
                    if (cmplt_valid_i) begin
                        state <= ST_CMP_CMD;
                    end
                end
                ST_CMP_CMD: begin
                    if (o_icb_cmd_ready) begin
                        state <= ST_CMP_RSP;
                    end
                end
                ST_CMP_RSP: begin
                    if (o_icb_rsp_valid) begin
                        state     <= ST_IDLE;
                        rearm_cnt <= CNT_W'(REARM_DLY);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All outputs decode the state register only, so no input reaches an output combinationally.
    assign o_icb_cmd_valid = (state == ST_CLM_CMD) || (state == ST_CMP_CMD);
    assign o_icb_cmd_read  = (state == ST_CLM_CMD);
    assign o_icb_cmd_addr  = o_icb_cmd_valid ? CLAIM_ADDR : 32'd0;
    assign o_icb_cmd_wdata = (state == ST_CMP_CMD) ? {{(32-ID_W){1'b0}}, id} : 32'd0;
    assign o_icb_rsp_ready = (state == ST_CLM_RSP) || (state == ST_CMP_RSP);
    assign claim_valid_o   = (state == ST_PRESENT);
    assign claim_id_o      = (state == ST_PRESENT) ? id : '0;
    assign cmplt_ready_o   = (state == ST_WAIT_CMP);
    assign busy_o          = (state != ST_IDLE);

endmodule
